// File: rtl/sar_seq.sv
// SAR conversion sequencer: samples, settles, resolves N_BITS MSB-first and
// presents the registered code with a one-cycle valid strobe.
module sar_seq #(
    parameter int N_BITS = 12,
    parameter int SMP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [SMP_W-1:0]  sample_len,
    input  logic              comp,
    output logic [N_BITS-1:0] dtop,
    output logic [N_BITS-1:0] dbot,
    output logic              sample,
    output logic              busy,
    output logic [N_BITS-1:0] data_out,
    output logic              data_valid,
    output logic [2:0]        state_o
);

    localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        SETTLE  = 3'd2,
        CONVERT = 3'd3,
        EOC     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [SMP_W-1:0]  smp_cnt;
    logic [SMP_W-1:0]  smp_load;
    logic [CNT_W-1:0]  bit_cnt;
    logic [N_BITS-1:0] result;
    logic [N_BITS-1:0] res_d, dtop_d, dbot_d;
    logic              smp_done, bit_done;

    // A zero sampling length still gets one SAMPLE cycle.
    assign smp_load = (sample_len == '0) ? '0 : sample_len - 1'b1;
    assign smp_done = (smp_cnt == '0);
    assign bit_done = (bit_cnt == '0);

    assign sample  = (state_q == SAMPLE);
    assign busy    = (state_q != IDLE);
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SAMPLE;
            SAMPLE:  if (smp_done) state_d = SETTLE;
            SETTLE:  state_d = CONVERT;
            CONVERT: if (bit_done) state_d = EOC;
            EOC:     state_d = cont ? SAMPLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Current bit decision folded into the switch words and partial result.
    always_comb begin
        res_d  = result;
        dtop_d = dtop;
        dbot_d = dbot;
        res_d[bit_cnt]  = comp;
        dtop_d[bit_cnt] = ~comp;
        dbot_d[bit_cnt] = comp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_cnt    <= '0;
            bit_cnt    <= '0;
            result     <= '0;
            dtop       <= '1;
            dbot       <= '1;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    dtop <= '1;
                    dbot <= '1;
                    if (start) smp_cnt <= smp_load;
                end
                SAMPLE: begin
                    dtop <= '1;
                    dbot <= '1;
                    if (!smp_done) smp_cnt <= smp_cnt - 1'b1;
                end
                SETTLE: begin
                    bit_cnt <= CNT_W'(N_BITS - 1);
                end
                CONVERT: begin
                    dtop   <= dtop_d;
                    dbot   <= dbot_d;
                    result <= res_d;
                    if (bit_done) begin
                        data_out   <= res_d;
                        data_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                EOC: begin
                    dtop <= '1;
                    dbot <= '1;
                    if (cont) smp_cnt <= smp_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sar_seq.md
# sar_seq

Parametrised SAR conversion sequencer, the successor to the fixed 12-bit SAR controller. It drives the capacitive DAC top/bottom switch words and the sampling switch of the SAR ADC macro. Additions over the previous generation:
- N_BITS-generic bit counter.
- Start/valid handshake with an IDLE state.
- Programmable sampling length.
- Explicit comparator settle cycle.
- Continuous (free-running) mode.
- Registered parallel result with a one-cycle valid strobe.

## Interface
- N_BITS, 12, conversion resolution; legal range 2..16.
- SMP_W, 4, width of the sampling-length input.
- clk  input  1  conversion clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- cont  input  1  continuous mode; sampled in EOC.
- sample_len  input  SMP_W  number of SAMPLE cycles; 0 is treated as 1; latched on entry to SAMPLE.
- comp  input  1  comparator decision, valid in CONVERT cycles.
- dtop  output  N_BITS  top-plate DAC switch word.
- dbot  output  N_BITS  bottom-plate DAC switch word.
- sample  output  1  sampling switch enable.
- busy  output  1  high whenever state is not IDLE.
- data_out  output  N_BITS  last completed conversion result.
- data_valid  output  1  one-cycle strobe: data_out is new.
- state_o  output  3  current state: IDLE=0, SAMPLE=1, SETTLE=2, CONVERT=3, EOC=4.

## Operation
- State machine: IDLE -> SAMPLE -> SETTLE -> CONVERT -> EOC -> (SAMPLE if cont, else IDLE).
- IDLE: wait for start=1, then go to SAMPLE and latch sample_len into the sample counter.
- SAMPLE: lasts L = max(sample_len,1) cycles, then SETTLE.
- SETTLE: exactly 1 cycle with no decision, for comparator/DAC settling; then CONVERT.
- CONVERT: lasts N_BITS cycles. The bit index k runs N_BITS-1 down to 0, MSB first.
  - On the edge ending each CONVERT cycle k: dtop[k] <= !comp, dbot[k] <= comp, result[k] <= comp.
  - After k=0, go to EOC.
- EOC: 1 cycle.
  - cont=1: go to SAMPLE and re-latch sample_len.
  - cont=0: go to IDLE.
- start while not in IDLE is ignored; there is no abort.
- dtop/dbot:
  - Loaded with all ones on any edge where the current state is IDLE, SAMPLE or EOC.
  - Held in SETTLE.
  - Bitwise updated in CONVERT.
  - During EOC they show the final code.
- data_out/data_valid:
  - On the edge ending CONVERT k=0, data_out gets the full result, including the final bit, and data_valid goes high for exactly that one following cycle (the EOC cycle).
  - data_out holds until the next completion.
- sample = (state == SAMPLE); busy = (state != IDLE). Both are decoded from the state register.
- Bit counter width is $clog2(N_BITS). It is loaded with N_BITS-1 on entering CONVERT and never wraps below 0 in use.
- Sample counter width is SMP_W. It is loaded with L-1 and counts down to 0.

## Timing
- Reset (rst=1 at an edge) sets the following on the next cycle:
  - state = IDLE, dtop = dbot = all ones.
  - data_out = 0, data_valid = 0, sample = 0, busy = 0.
  - Counters = 0.
- Reset mid-conversion behaves the same: the conversion is discarded and no data_valid is produced.
- Reset has priority over start.
- Latency, with start seen at edge E0:
  - SAMPLE occupies cycles 1..L.
  - SETTLE occupies cycle L+1.
  - CONVERT occupies cycles L+2..L+N_BITS+1.
  - data_valid is high in cycle L+N_BITS+2.
  - Default case (L=4, N_BITS=12): data_valid in cycle 18.
- Continuous throughput: one result every L+N_BITS+2 cycles (SAMPLE re-entered directly from EOC, no IDLE cycle).
- Back-to-back single mode: EOC -> IDLE. If start=1 in that IDLE cycle, SAMPLE begins the next cycle, giving a period of L+N_BITS+3.
- sample_len changes outside the latch point have no effect on the conversion in progress.

## Test plan
- Reset then idle: rst=1 for 2 cycles, start=0 -> state_o=0, dtop=dbot=0xFFF, data_out=0, busy=0, sample=0 for 10 cycles.
- Single conversion, N_BITS=12, sample_len=4, comp pattern 101100111010 MSB first -> sample high cycles 1-4, data_valid only in cycle 18, data_out=0xB3A, dtop=0x4C5 and dbot=0xB3A during EOC, then IDLE with dtop=dbot=0xFFF.
- sample_len=0 -> SAMPLE lasts 1 cycle, data_valid in cycle N_BITS+3=15.
- Continuous mode, cont=1, sample_len=2, comp alternating per conversion (all 1s then all 0s) -> data_valid every 16 cycles, data_out 0xFFF then 0x000, busy never drops.
- start pulsed during CONVERT and rst asserted at CONVERT k=5 -> start ignored (no extra conversion). After reset: IDLE, no data_valid, data_out=0.
- Parameter sweep N_BITS=2 and N_BITS=16 (SMP_W=4, sample_len=15) with random comp -> data_out matches the comp bit sequence, data_valid at L+N_BITS+2.
